d_memory_model: RTL and testbench
=================================

Name: d_memory_model

Overview:
- Behavioural data-memory slave that sits directly downstream of the memory controller and answers its memory_* request/ack interface.
- Accepts one load or store at a time and holds it for a fixed, parameterised access latency.
- Returns load data with a single-cycle ack; performs store writes into an internal word array.
- Used in the core testbench and in integration simulation as the data-side memory.

Parameters:
- DEPTH_WORDS, 256: number of REG_VAL_WIDTH-bit words; must be a power of 2, ≥2.
- LATENCY, 4: cycles from the request-sampled edge to the ack cycle; must be ≥1.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low (asserted at 0).
- memory_req_valid  input  1  single-cycle request strobe from controller.
- memory_req_op  input  memory_op_t  no_mem_op / load_op / store_op.
- memory_req_address  input  `D_MEMORY_ADDR_WIDTH  byte address; word-aligned.
- memory_req_data  input  `REG_VAL_WIDTH  store data.
- memory_ready  output  1  slave can accept a request this cycle.
- memory_ack  output  1  one-cycle completion pulse.
- memory_data_return  output  `REG_VAL_WIDTH  load data; valid only while memory_ack=1.
- mem_addr_err  output  1  sticky: out-of-range or misaligned access seen.
- mem_protocol_err  output  1  sticky: memory_req_valid seen while not IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; memory_ready=0 while reset is held.
  - memory_ack=0, memory_data_return=0, both error flags=0, countdown=0.
  - All array words=0; any in-flight request is aborted with no write.
- First cycle after reset release: memory_ready=1.
- States: IDLE, ACCESS, RESPOND.
- IDLE:
  - memory_ready=1.
  - On memory_req_valid=1: capture op, address and data.
  - LATENCY=1: next state is RESPOND.
  - LATENCY>1: next state is ACCESS with countdown=LATENCY-2.
- ACCESS:
  - memory_ready=0.
  - Countdown decrements each cycle; at countdown=0 the next state is RESPOND.
- Array access happens on the edge entering RESPOND:
  - load_op: memory_data_return <= array[index].
  - store_op: array[index] <= captured data; memory_data_return <= 0.
  - no_mem_op: no array access; memory_data_return <= 0.
- RESPOND:
  - memory_ack=1 and memory_ready=0 for exactly one cycle.
  - Next state is IDLE; memory_data_return clears to 0 on that edge.
- Latency: if valid is sampled at edge E, memory_ack is high during the cycle after edge E+LATENCY-1. Ack therefore occurs LATENCY cycles after the valid cycle.
- Back-to-back: ready returns to 1 the cycle after the ack. Minimum request spacing is LATENCY+1 cycles.
- Index: index = address[log2(DEPTH_WORDS)+1 : 2].
- Address errors: a request is an address error if address[1:0]≠0 or any address bit above log2(DEPTH_WORDS)+1 is nonzero. For such a request:
  - Still acked after LATENCY cycles.
  - Load returns 0; store is dropped.
  - mem_addr_err sets and stays set until reset.
- Protocol errors: memory_req_valid=1 in ACCESS or RESPOND is ignored (no capture, no effect on the current op) and sets mem_protocol_err.
- memory_ready is a combinational decode of state==IDLE. memory_ack is a combinational decode of state==RESPOND. memory_data_return is registered.
- Store then load to the same address: the load returns the new data, because the write commits before the store ack.
- Reset asserted mid-ACCESS or mid-RESPOND: immediate return to IDLE values, no ack emitted, array cleared.

Test Plan:
(All with REG_VAL_WIDTH=32, DEPTH_WORDS=256, LATENCY=4.)
- Store then load: store addr 0x10 data 0xDEADBEEF, wait for ack, then load 0x10 -> ack exactly 4 cycles after each valid; load returns 0xDEADBEEF on its ack cycle; data is 0 on all other cycles.
- Reset contents: load 0x3FC (index 255) after reset -> returns 0x00000000; no error flags set.
- Address errors: load 0x402 (misaligned), then store 0x400 (out of range) -> both acked; load returns 0; mem_addr_err=1 and stays 1; array index 0 is unchanged (load 0x0 returns 0).
- Protocol error: pulse memory_req_valid 2 cycles after an accepted load -> the original ack still arrives on schedule with correct data; mem_protocol_err=1; no second ack.
- Reset mid-access: store 0x20 data 0x12345678, assert reset during ACCESS -> no ack; after release, load 0x20 returns 0; ready high the first cycle after release.
- LATENCY=1 build: load issued in the IDLE cycle -> ack on the very next cycle; ready low only during the ack cycle; a back-to-back request is accepted the cycle after the ack.

Source files
------------

// File: rtl/d_memory_model.sv
// Behavioural data-side memory that answers the memory controller's request/ack port.
// It serves one load or store at a time with a fixed access latency and a one-cycle ack.
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 32
`endif

package d_memory_model_pkg;
  typedef enum logic [1:0] {
    no_mem_op = 2'd0,
    load_op   = 2'd1,
    store_op  = 2'd2
  } memory_op_t;
endpackage

module d_memory_model
  import d_memory_model_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            memory_req_valid,
  input  memory_op_t                      memory_req_op,
  input  logic [`D_MEMORY_ADDR_WIDTH-1:0] memory_req_address,
  input  logic [`REG_VAL_WIDTH-1:0]       memory_req_data,
  output logic                            memory_ready,
  output logic                            memory_ack,
  output logic [`REG_VAL_WIDTH-1:0]       memory_data_return,
  output logic                            mem_addr_err,
  output logic                            mem_protocol_err
);
  localparam int DW       = `REG_VAL_WIDTH;
  localparam int AW       = `D_MEMORY_ADDR_WIDTH;
  localparam int IDX_W    = $clog2(DEPTH_WORDS);
  localparam int CNT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_count;
  memory_op_t         r_op;
  logic [AW-1:0]      r_addr;
  logic [DW-1:0]      r_wdata;
  logic [DW-1:0]      r_rdata;
  logic               r_addr_err;
  logic               r_proto_err;
  logic [DW-1:0]      r_mem [DEPTH_WORDS];

  logic               w_accept;
  memory_op_t         w_acc_op;
  logic [AW-1:0]      w_acc_addr;
  logic [DW-1:0]      w_acc_data;
  logic               w_acc_err;
  logic [IDX_W-1:0]   w_acc_idx;
  logic               w_do_access;

  assign w_accept = (r_state == IDLE) && memory_req_valid;

  // With LATENCY=1 the access happens on the accepting edge, so the live request is used.
  assign w_acc_op   = (r_state == IDLE) ? memory_req_op      : r_op;
  assign w_acc_addr = (r_state == IDLE) ? memory_req_address : r_addr;
  assign w_acc_data = (r_state == IDLE) ? memory_req_data    : r_wdata;
  assign w_acc_err  = (w_acc_addr[1:0] != 2'b00) || ((w_acc_addr >> (IDX_W + 2)) != '0);
  assign w_acc_idx  = w_acc_addr[IDX_W+1:2];

  assign w_do_access = (w_next_state == RESPOND) && (r_state != RESPOND);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: the default assignment first guarantees every path drives w_next_state,
  // which keeps this block purely combinational (no inferred latch).
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (memory_req_valid) w_next_state = (LATENCY == 1) ? RESPOND : ACCESS;
      ACCESS:  if (r_count == '0) w_next_state = RESPOND;
      RESPOND: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: the word array is cleared by reset because simulations depend on known-zero
  // contents; a real SRAM macro has no reset and would not be written this way.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count     <= '0;
      r_op        <= no_mem_op;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_addr_err  <= 1'b0;
      r_proto_err <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= memory_req_op;
        r_addr  <= memory_req_address;
        r_wdata <= memory_req_data;
        r_count <= CNT_W'(CNT_INIT);
        if (w_acc_err) r_addr_err <= 1'b1;
      end else if ((r_state == ACCESS) && (r_count != '0)) begin
        r_count <= r_count - CNT_W'(1);
      end

      if (memory_req_valid && (r_state != IDLE)) r_proto_err <= 1'b1;

      r_rdata <= '0;
      if (w_do_access && !w_acc_err) begin
        if (w_acc_op == load_op)  r_rdata <= r_mem[w_acc_idx];
        if (w_acc_op == store_op) r_mem[w_acc_idx] <= w_acc_data;
      end
    end
  end

  // Ready is forced low while reset is held even though the state already reads IDLE.
  assign memory_ready       = (r_state == IDLE) && reset;
  assign memory_ack         = (r_state == RESPOND);
  assign memory_data_return = r_rdata;
  assign mem_addr_err       = r_addr_err;
  assign mem_protocol_err   = r_proto_err;

endmodule

// File: tb/tb_d_memory_model.sv
// Randomized self-checking bench for d_memory_model; builds LATENCY=4 and LATENCY=1
// instances and compares them against a word-array reference model.
module tb_d_memory_model;
  import d_memory_model_pkg::*;

  localparam int DEPTH = 256;

  logic        clk;
  logic        reset;
  logic        valid  [2];
  memory_op_t  op     [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        ready  [2];
  logic        ack    [2];
  logic [31:0] rdata  [2];
  logic        aerr   [2];
  logic        perr   [2];

  logic [31:0] ref_mem  [2][DEPTH];
  bit          ref_aerr [2];
  bit          ref_perr [2];

  int num_tests = 0;
  int num_fail  = 0;

  d_memory_model #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .memory_req_valid(valid[0]), .memory_req_op(op[0]),
    .memory_req_address(addr[0]), .memory_req_data(wdata[0]),
    .memory_ready(ready[0]), .memory_ack(ack[0]), .memory_data_return(rdata[0]),
    .mem_addr_err(aerr[0]), .mem_protocol_err(perr[0])
  );

  d_memory_model #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .memory_req_valid(valid[1]), .memory_req_op(op[1]),
    .memory_req_address(addr[1]), .memory_req_data(wdata[1]),
    .memory_ready(ready[1]), .memory_ack(ack[1]), .memory_data_return(rdata[1]),
    .mem_addr_err(aerr[1]), .mem_protocol_err(perr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_tests++;
    if (got !== exp) begin
      num_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int sel);
    return (sel == 0) ? 4 : 1;
  endfunction

  function automatic bit is_addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[s][i] = '0;
      ref_aerr[s] = 1'b0;
      ref_perr[s] = 1'b0;
    end
  endtask

  task automatic check_flags(input int sel);
    check($sformatf("addr_err%0d", sel),  32'(aerr[sel]), 32'(ref_aerr[sel]));
    check($sformatf("proto_err%0d", sel), 32'(perr[sel]), 32'(ref_perr[sel]));
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the ack cycle.
  task automatic xact(input int sel, input memory_op_t o, input logic [31:0] a,
                      input logic [31:0] d, input int glitch);
    logic [31:0] exp_data;
    bit          err;
    int          lat;
    lat = lat_of(sel);
    check($sformatf("ready_pre%0d", sel), 32'(ready[sel]), 32'd1);
    err      = is_addr_err(a);
    exp_data = '0;
    if (err) ref_aerr[sel] = 1'b1;
    else if (o == load_op)  exp_data = ref_mem[sel][a[9:2]];
    else if (o == store_op) ref_mem[sel][a[9:2]] = d;
    valid[sel] = 1'b1; op[sel] = o; addr[sel] = a; wdata[sel] = d;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      valid[sel] = 1'b0;
      if (k < lat) begin
        check($sformatf("ack_early%0d", sel),  32'(ack[sel]), 32'd0);
        check($sformatf("data_early%0d", sel), rdata[sel], 32'd0);
      end else begin
        check($sformatf("ack%0d", sel),  32'(ack[sel]), 32'd1);
        check($sformatf("data%0d", sel), rdata[sel], exp_data);
      end
      check($sformatf("ready_busy%0d", sel), 32'(ready[sel]), 32'd0);
      if (glitch == k) begin
        valid[sel] = 1'b1; op[sel] = store_op; addr[sel] = a & 32'h3FC; wdata[sel] = $urandom;
        ref_perr[sel] = 1'b1;
      end
    end
    @(negedge clk);
    valid[sel] = 1'b0;
    check($sformatf("ack_post%0d", sel),   32'(ack[sel]), 32'd0);
    check($sformatf("data_post%0d", sel),  rdata[sel], 32'd0);
    check($sformatf("ready_post%0d", sel), 32'(ready[sel]), 32'd1);
    check_flags(sel);
  endtask

  task automatic idle(input int sel, input int n);
    repeat (n) begin
      @(negedge clk);
      check($sformatf("ack_idle%0d", sel),   32'(ack[sel]), 32'd0);
      check($sformatf("ready_idle%0d", sel), 32'(ready[sel]), 32'd1);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] idx;
    int          r;
    r   = int'($urandom_range(0, 9));
    idx = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, DEPTH - 1))
                                      : 32'($urandom_range(0, 15));
    if (r == 0)      return (idx << 2) | 32'($urandom_range(1, 3));
    else if (r == 1) return (32'($urandom_range(1, 1000)) << 10) | (idx << 2);
    else             return idx << 2;
  endfunction

  task automatic random_phase(input int sel, input int n);
    memory_op_t o;
    int         g;
    for (int t = 0; t < n; t++) begin
      o = memory_op_t'($urandom_range(0, 2));
      g = (sel == 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0;
      xact(sel, o, rand_addr(), $urandom, g);
      idle(sel, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      valid[s] = 1'b0; op[s] = no_mem_op; addr[s] = '0; wdata[s] = '0;
    end
    clear_model();

    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst_ready%0d", s), 32'(ready[s]), 32'd0);
      check($sformatf("rst_ack%0d", s),   32'(ack[s]),   32'd0);
      check($sformatf("rst_data%0d", s),  rdata[s],      32'd0);
      check_flags(s);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_ready0", 32'(ready[0]), 32'd1);
    check("rel_ready1", 32'(ready[1]), 32'd1);

    for (int s = 0; s < 2; s++) begin
      xact(s, store_op, 32'h10, 32'hDEADBEEF, 0);
      xact(s, load_op,  32'h10, 32'h0, 0);
      xact(s, load_op,  32'h3FC, 32'h0, 0);
      xact(s, no_mem_op, 32'h40, 32'h0, 0);
    end

    for (int s = 0; s < 2; s++) begin
      xact(s, load_op,  32'h402, 32'h0, 0);
      xact(s, store_op, 32'h400, 32'hCAFEF00D, 0);
      xact(s, load_op,  32'h0,   32'h0, 0);
    end

    xact(0, store_op, 32'h44, 32'hA5A5_0001, 0);
    xact(0, load_op,  32'h44, 32'h0, 2);
    idle(0, 3);
    xact(0, load_op,  32'h10, 32'h0, 4);

    random_phase(0, 60);
    random_phase(1, 80);

    // Reset in the middle of a store: no ack, no write, array and flags cleared.
    xact(0, store_op, 32'h20, 32'hAAAA_5555, 0);
    valid[0] = 1'b1; op[0] = store_op; addr[0] = 32'h20; wdata[0] = 32'h12345678;
    @(negedge clk);
    valid[0] = 1'b0;
    @(negedge clk);
    check("mid_ack_before", 32'(ack[0]), 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready[0]), 32'd0);
    check("mid_rst_ack",   32'(ack[0]),   32'd0);
    @(negedge clk);
    reset = 1'b1;
    clear_model();
    #1;
    check("mid_rel_ready0", 32'(ready[0]), 32'd1);
    check("mid_rel_ready1", 32'(ready[1]), 32'd1);
    check_flags(0);
    check_flags(1);
    idle(0, 5);
    xact(0, load_op, 32'h20, 32'h0, 0);
    xact(0, load_op, 32'h10, 32'h0, 0);
    xact(1, load_op, 32'h10, 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", num_tests, num_fail);
    $finish;
  end

endmodule
